dual_issue_scheduler: RTL and testbench
=======================================

Name: dual_issue_scheduler

Overview:
In-order 2-wide issue scheduler between the decode queue and two execution ports.
- Pulls an instruction pair (slot0 older, slot1 younger) from the decode queue.
- Checks intra-pair RAW/WAW hazards, port capability and a 32-entry register scoreboard.
- Issues 0, 1 or 2 instructions per cycle; slot1 never issues ahead of slot0.

Parameters:
NREG, 32, architectural register count (scoreboard depth)
RADDR_W, 5, register address width

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
o_sch_dque_request  out  1  scheduler can accept a new pair this cycle
i_dque_sch_ready  in  1  decode queue presents a valid pair; transfer = request && ready
i_d0_valid / i_d1_valid  in  1  slot valid
i_d0_funct / i_d1_funct  in  3  0=ALU 1=BRC 2=LSU 3=MUL 4=DIV
i_d0_rd / i_d1_rd, i_d0_rs1 / i_d1_rs1, i_d0_rs2 / i_d1_rs2  in  RADDR_W  register addresses
i_d0_rd_wr / i_d1_rd_wr  in  1  instruction writes rd
o_iss0_valid / o_iss1_valid  out  1  port issue valid (port0 = ALU/BRC/LSU, port1 = ALU/MUL/DIV)
o_iss0_funct / o_iss1_funct  out  3  issued funct
o_iss0_rd / o_iss1_rd, o_iss0_rs1 / o_iss1_rs1, o_iss0_rs2 / o_iss1_rs2  out  RADDR_W  issued addresses
i_iss0_ready / i_iss1_ready  in  1  port accepts; issue = valid && ready
i_wb_valid  in  1  writeback completes
i_wb_rd  in  RADDR_W  writeback register, clears its scoreboard bit
i_flush  in  1  discard buffered instructions

Behaviour:
- Reset (async, i_rstn low):
  - state=EMPTY, scoreboard=0, o_sch_dque_request=1.
  - o_iss*_valid=0; all payload outputs are 0 while their valid is low.
- States:
  - EMPTY: no buffered instruction.
  - FULL: slot0 and slot1 pending.
  - HALF: slot1 only pending.
- Transfer (request && ready):
  - Latch the pair, go to FULL.
  - A slot loaded with valid=0 counts as already consumed: pair {1,0} behaves as single; pair {0,0} returns to EMPTY the next cycle.
- o_sch_dque_request is asserted when any of these holds:
  - state==EMPTY;
  - all remaining valid slots issue this cycle;
  - i_flush is high.
  This allows back-to-back pairs with no bubble.
- Latency: earliest issue is in the cycle after the load edge. Issue outputs are combinational from the buffer, scoreboard and port readies.
- Funct values 5-7 are treated as ALU.
- Slot issuable when the scoreboard bits of rs1, rs2 and (if rd_wr) rd are all clear. Register 0 is never busy.
- Dual issue (FULL) requires all of:
  - both slots issuable;
  - no RAW: slot1 rs1/rs2 != slot0 rd (when slot0 rd_wr and rd!=0);
  - no WAW: identical nonzero rd with both rd_wr;
  - the two slots do not both need the same exclusive port ({BRC,LSU} port0-only, {MUL,DIV} port1-only);
  - both target ports ready.
- Dual routing:
  - ALU+ALU: slot0 to port0, slot1 to port1.
  - Otherwise each exclusive-class slot goes to its port and the ALU slot takes the other port.
- Single issue (slot0 in FULL, or slot1 in HALF):
  - Exclusive class goes to its port if that port is ready.
  - ALU prefers port0 and falls back to port1 when port0 is not ready.
- FULL transitions: dual issue -> EMPTY, or FULL on a same-cycle reload. Slot0 only -> HALF. No issue -> stay.
- HALF transitions: slot1 issues -> EMPTY, or FULL on reload.
- Scoreboard:
  - On issue of an rd_wr instruction with rd!=0, set bit[rd].
  - On i_wb_valid with i_wb_rd!=0, clear bit[i_wb_rd].
  - Same register set and cleared in the same cycle: set wins.
- i_flush: buffer discarded and state goes to EMPTY next edge; o_iss*_valid forced 0 in that cycle. The scoreboard is retained (in-flight writebacks still clear their bits). A transfer in the same cycle as a flush is accepted and loads FULL.
- Reset mid-operation clears the buffer and scoreboard immediately.

Test Plan:
- Independent pair ALU rd=1 rs=2,3 and MUL rd=4 rs=5,6, both ports ready -> same cycle port0 ALU rd=1, port1 MUL rd=4; bits 1 and 4 set; request=1 that cycle.
- RAW pair: slot0 ALU rd=5; slot1 ALU rs1=5 -> slot0 issues on port0 in cycle N; slot1 stalls until i_wb_rd=5, then issues the cycle after writeback.
- Port conflict LSU+BRC, independent registers -> LSU on port0 in cycle N, BRC on port0 in cycle N+1; state FULL->HALF->EMPTY.
- Single ALU with i_iss0_ready=0, i_iss1_ready=1 -> issues on port1; with both ports not ready, nothing issues and outputs are held.
- WAW: both slots rd=7 -> serialized. After slot0 issues, slot1 waits for writeback of rd=7.
- Same-cycle issue set rd=9 and writeback rd=9 -> bit 9 stays set. i_flush in HALF -> EMPTY, no issue, scoreboard unchanged. Async reset mid-FULL -> valids drop to 0 immediately.

Source files
------------

// File: rtl/dual_issue_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_scheduler_if
// Brief    : Decode-queue pair, issue-port and writeback bundle for the
//            dual-issue scheduler. master = scheduler side, slave = environment.
// Revision : 1.0  initial release
// ============================================================================
interface dual_issue_scheduler_if #(
   parameter int RADDR_W = 5
);
   logic               o_sch_dque_request;
   logic               i_dque_sch_ready;
   logic               i_d0_valid, i_d1_valid;
   logic [2:0]         i_d0_funct, i_d1_funct;
   logic [RADDR_W-1:0] i_d0_rd, i_d1_rd, i_d0_rs1, i_d1_rs1, i_d0_rs2, i_d1_rs2;
   logic               i_d0_rd_wr, i_d1_rd_wr;
   logic               o_iss0_valid, o_iss1_valid;
   logic [2:0]         o_iss0_funct, o_iss1_funct;
   logic [RADDR_W-1:0] o_iss0_rd, o_iss1_rd, o_iss0_rs1, o_iss1_rs1, o_iss0_rs2, o_iss1_rs2;
   logic               i_iss0_ready, i_iss1_ready;
   logic               i_wb_valid;
   logic [RADDR_W-1:0] i_wb_rd;
   logic               i_flush;

   modport master (
      output o_sch_dque_request,
      input  i_dque_sch_ready,
      input  i_d0_valid, i_d1_valid, i_d0_funct, i_d1_funct,
      input  i_d0_rd, i_d1_rd, i_d0_rs1, i_d1_rs1, i_d0_rs2, i_d1_rs2,
      input  i_d0_rd_wr, i_d1_rd_wr,
      output o_iss0_valid, o_iss1_valid, o_iss0_funct, o_iss1_funct,
      output o_iss0_rd, o_iss1_rd, o_iss0_rs1, o_iss1_rs1, o_iss0_rs2, o_iss1_rs2,
      input  i_iss0_ready, i_iss1_ready,
      input  i_wb_valid, i_wb_rd, i_flush
   );

   modport slave (
      input  o_sch_dque_request,
      output i_dque_sch_ready,
      output i_d0_valid, i_d1_valid, i_d0_funct, i_d1_funct,
      output i_d0_rd, i_d1_rd, i_d0_rs1, i_d1_rs1, i_d0_rs2, i_d1_rs2,
      output i_d0_rd_wr, i_d1_rd_wr,
      input  o_iss0_valid, o_iss1_valid, o_iss0_funct, o_iss1_funct,
      input  o_iss0_rd, o_iss1_rd, o_iss0_rs1, o_iss1_rs1, o_iss0_rs2, o_iss1_rs2,
      output i_iss0_ready, i_iss1_ready,
      output i_wb_valid, i_wb_rd, i_flush
   );
endinterface
`default_nettype wire

// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_scheduler
// Brief    : In-order 2-wide issue scheduler. Buffers one decode pair, checks
//            intra-pair RAW/WAW, port capability and a register scoreboard,
//            and issues 0, 1 or 2 instructions per cycle (slot1 never first).
// Revision : 1.0  initial release
// ============================================================================
module dual_issue_scheduler #(
   parameter int NREG    = 32,
   parameter int RADDR_W = 5
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   dual_issue_scheduler_if.master bus
);
   typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_HALF = 2'd2} state_t;

   // v marks a slot still waiting to issue; wr is the rd write-enable
   typedef struct packed {
      logic               v;
      logic [2:0]         f;
      logic [RADDR_W-1:0] rd;
      logic [RADDR_W-1:0] rs1;
      logic [RADDR_W-1:0] rs2;
      logic               wr;
   } slot_t;

   state_t          state_q;
   slot_t           slot_q [2];
   logic [NREG-1:0] sb_q, sb_d;
   slot_t           ld_slot0, ld_slot1;
   logic            pend0, pend1, ok0, ok1, raw, waw, clash, dual;
   logic            hd_sel, hd_ok;
   logic [2:0]      hd_f;
   logic            use0, use1, sel0, sel1;
   logic            iss_s0, iss_s1, rem0, rem1, req, xfer;

   // BRC/LSU may only go to port0
   function automatic logic excl0(input logic [2:0] f);
      return (f == 3'd1) || (f == 3'd2);
   endfunction

   // MUL/DIV may only go to port1
   function automatic logic excl1(input logic [2:0] f);
      return (f == 3'd3) || (f == 3'd4);
   endfunction

   function automatic logic busy(input logic [NREG-1:0] sb, input logic [RADDR_W-1:0] r);
      return (r != '0) && sb[r];
   endfunction

   function automatic logic clear_to_go(input slot_t s, input logic [NREG-1:0] sb);
      return !busy(sb, s.rs1) && !busy(sb, s.rs2) && !(s.wr && busy(sb, s.rd));
   endfunction

   assign ld_slot0 = {bus.i_d0_valid, bus.i_d0_funct, bus.i_d0_rd, bus.i_d0_rs1, bus.i_d0_rs2, bus.i_d0_rd_wr};
   assign ld_slot1 = {bus.i_d1_valid, bus.i_d1_funct, bus.i_d1_rd, bus.i_d1_rs1, bus.i_d1_rs2, bus.i_d1_rd_wr};

   // Issue decision: try the pair, otherwise the oldest pending slot alone
   always_comb begin
      pend0  = (state_q == ST_FULL) && slot_q[0].v;
      pend1  = (state_q != ST_EMPTY) && slot_q[1].v;
      ok0    = clear_to_go(slot_q[0], sb_q);
      ok1    = clear_to_go(slot_q[1], sb_q);
      raw    = slot_q[0].wr && (slot_q[0].rd != '0) &&
               ((slot_q[1].rs1 == slot_q[0].rd) || (slot_q[1].rs2 == slot_q[0].rd));
      waw    = slot_q[0].wr && slot_q[1].wr && (slot_q[0].rd != '0) &&
               (slot_q[0].rd == slot_q[1].rd);
      clash  = (excl0(slot_q[0].f) && excl0(slot_q[1].f)) ||
               (excl1(slot_q[0].f) && excl1(slot_q[1].f));
      dual   = !bus.i_flush && pend0 && pend1 && ok0 && ok1 && !raw && !waw && !clash &&
               bus.i_iss0_ready && bus.i_iss1_ready;
      hd_sel = !pend0;
      hd_ok  = !bus.i_flush && (pend0 ? ok0 : (pend1 && ok1));
      hd_f   = slot_q[hd_sel].f;
      use0   = 1'b0;
      use1   = 1'b0;
      sel0   = 1'b0;
      sel1   = 1'b0;
      if (dual) begin
         // slot0 lands on port1 if it is MUL/DIV, or an ALU paired with BRC/LSU
         use0 = 1'b1;
         use1 = 1'b1;
         sel0 = excl1(slot_q[0].f) || (!excl0(slot_q[0].f) && excl0(slot_q[1].f));
         sel1 = !sel0;
      end else if (hd_ok) begin
         if (!excl1(hd_f) && bus.i_iss0_ready) begin
            use0 = 1'b1;
            sel0 = hd_sel;
         end else if (!excl0(hd_f) && bus.i_iss1_ready) begin
            use1 = 1'b1;
            sel1 = hd_sel;
         end
      end
      iss_s0 = (use0 && !sel0) || (use1 && !sel1);
      iss_s1 = (use0 && sel0) || (use1 && sel1);
      rem0   = pend0 && !iss_s0;
      rem1   = pend1 && !iss_s1;
      req    = bus.i_flush || (state_q == ST_EMPTY) || (!rem0 && !rem1);
      xfer   = req && bus.i_dque_sch_ready;
   end

   assign bus.o_sch_dque_request = req;
   assign bus.o_iss0_valid = use0;
   assign bus.o_iss0_funct = use0 ? slot_q[sel0].f   : '0;
   assign bus.o_iss0_rd    = use0 ? slot_q[sel0].rd  : '0;
   assign bus.o_iss0_rs1   = use0 ? slot_q[sel0].rs1 : '0;
   assign bus.o_iss0_rs2   = use0 ? slot_q[sel0].rs2 : '0;
   assign bus.o_iss1_valid = use1;
   assign bus.o_iss1_funct = use1 ? slot_q[sel1].f   : '0;
   assign bus.o_iss1_rd    = use1 ? slot_q[sel1].rd  : '0;
   assign bus.o_iss1_rs1   = use1 ? slot_q[sel1].rs1 : '0;
   assign bus.o_iss1_rs2   = use1 ? slot_q[sel1].rs2 : '0;

   // Scoreboard next value: writeback clears first so a same-cycle issue set wins
   always_comb begin
      sb_d = sb_q;
      if (bus.i_wb_valid && (bus.i_wb_rd != '0)) sb_d[bus.i_wb_rd] = 1'b0;
      if (use0 && slot_q[sel0].wr && (slot_q[sel0].rd != '0)) sb_d[slot_q[sel0].rd] = 1'b1;
      if (use1 && slot_q[sel1].wr && (slot_q[sel1].rd != '0)) sb_d[slot_q[sel1].rd] = 1'b1;
   end

   // Buffer FSM: load on transfer (also during flush), otherwise retire issued slots
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= ST_EMPTY;
         slot_q[0] <= '0;
         slot_q[1] <= '0;
      end else if (xfer) begin
         state_q   <= ST_FULL;
         slot_q[0] <= ld_slot0;
         slot_q[1] <= ld_slot1;
      end else if (bus.i_flush) begin
         state_q <= ST_EMPTY;
      end else begin
         case (state_q)
            ST_FULL: begin
               if (!rem0 && !rem1) begin
                  state_q <= ST_EMPTY;
               end else if (!rem0) begin
                  state_q     <= ST_HALF;
                  slot_q[0].v <= 1'b0;
               end
            end
            ST_HALF: if (!rem1) state_q <= ST_EMPTY;
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

   // Scoreboard register
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) sb_q <= '0;
      else         sb_q <= sb_d;
   end
endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_issue_scheduler
// Brief    : Directed stimulus for dual_issue_scheduler with an in-order queue
//            reference model and hand-computed spot expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_dual_issue_scheduler;
   logic clk;
   logic rstn;
   int   checks = 0;
   int   fails  = 0;

   dual_issue_scheduler_if #(.RADDR_W(5)) bus ();
   dual_issue_scheduler #(.NREG(32), .RADDR_W(5)) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] f;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       wr;
   } ins_t;

   ins_t mq[$];     // pending instructions, oldest first
   bit   msb [32];  // registers with a write in flight

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // 0 = ALU (either port), 1 = port0 only, 2 = port1 only
   function automatic int cls(input logic [2:0] f);
      if (f == 3'd1 || f == 3'd2) return 1;
      if (f == 3'd3 || f == 3'd4) return 2;
      return 0;
   endfunction

   function automatic bit free(input ins_t x);
      return !(x.rs1 != 0 && msb[x.rs1]) && !(x.rs2 != 0 && msb[x.rs2]) &&
             !(x.wr && x.rd != 0 && msb[x.rd]);
   endfunction

   function automatic bit pair_ok(input ins_t a, input ins_t b);
      if (a.wr && a.rd != 0 && (b.rs1 == a.rd || b.rs2 == a.rd)) return 0;
      if (a.wr && b.wr && a.rd != 0 && a.rd == b.rd) return 0;
      if (cls(a.f) != 0 && cls(a.f) == cls(b.f)) return 0;
      return 1;
   endfunction

   function automatic ins_t mk(input logic [2:0] f, input logic [4:0] rd, rs1, rs2, input logic wr);
      return {f, rd, rs1, rs2, wr};
   endfunction

   // Reference compare every cycle out of reset, then advance the model
   always @(negedge clk) begin
      ins_t a, b, e0, e1;
      bit   v0, v1, ereq;
      int   n;
      if (!rstn) begin
         mq.delete();
         foreach (msb[i]) msb[i] = 0;
      end else begin
         v0 = 0; v1 = 0; e0 = '0; e1 = '0; n = 0; a = '0; b = '0;
         if (!bus.i_flush && mq.size() > 0) begin
            a = mq[0];
            if (mq.size() == 2) b = mq[1];
            if (mq.size() == 2 && free(a) && free(b) && pair_ok(a, b) &&
                bus.i_iss0_ready && bus.i_iss1_ready) begin
               n = 2; v0 = 1; v1 = 1;
               if (cls(a.f) == 2 || (cls(a.f) == 0 && cls(b.f) == 1)) begin
                  e1 = a; e0 = b;
               end else begin
                  e0 = a; e1 = b;
               end
            end else if (free(a)) begin
               if (cls(a.f) != 2 && bus.i_iss0_ready) begin
                  n = 1; v0 = 1; e0 = a;
               end else if (cls(a.f) != 1 && bus.i_iss1_ready) begin
                  n = 1; v1 = 1; e1 = a;
               end
            end
         end
         ereq = (mq.size() == 0) || bus.i_flush || (n == mq.size());
         chk("model_port0",
             {bus.o_iss0_valid, bus.o_iss0_funct, bus.o_iss0_rd, bus.o_iss0_rs1, bus.o_iss0_rs2},
             {v0, e0.f, e0.rd, e0.rs1, e0.rs2});
         chk("model_port1",
             {bus.o_iss1_valid, bus.o_iss1_funct, bus.o_iss1_rd, bus.o_iss1_rs1, bus.o_iss1_rs2},
             {v1, e1.f, e1.rd, e1.rs1, e1.rs2});
         chk("model_request", bus.o_sch_dque_request, ereq);
         if (bus.i_wb_valid && bus.i_wb_rd != 0) msb[bus.i_wb_rd] = 0;
         if (v0 && e0.wr && e0.rd != 0) msb[e0.rd] = 1;
         if (v1 && e1.wr && e1.rd != 0) msb[e1.rd] = 1;
         repeat (n) void'(mq.pop_front());
         if (bus.i_flush) mq.delete();
         if (ereq && bus.i_dque_sch_ready) begin
            mq.delete();
            if (bus.i_d0_valid)
               mq.push_back({bus.i_d0_funct, bus.i_d0_rd, bus.i_d0_rs1, bus.i_d0_rs2, bus.i_d0_rd_wr});
            if (bus.i_d1_valid)
               mq.push_back({bus.i_d1_funct, bus.i_d1_rd, bus.i_d1_rs1, bus.i_d1_rs2, bus.i_d1_rd_wr});
         end
      end
   end

   // Advance n clock edges and land just after the last one
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present a pair for one cycle
   task automatic send(input ins_t s0, input logic v0, input ins_t s1, input logic v1);
      {bus.i_d0_funct, bus.i_d0_rd, bus.i_d0_rs1, bus.i_d0_rs2, bus.i_d0_rd_wr} = s0;
      {bus.i_d1_funct, bus.i_d1_rd, bus.i_d1_rs1, bus.i_d1_rs2, bus.i_d1_rd_wr} = s1;
      bus.i_d0_valid = v0;
      bus.i_d1_valid = v1;
      bus.i_dque_sch_ready = 1'b1;
      cyc(1);
      bus.i_dque_sch_ready = 1'b0;
      bus.i_d0_valid = 1'b0;
      bus.i_d1_valid = 1'b0;
   endtask

   task automatic wb(input logic [4:0] rd);
      bus.i_wb_valid = 1'b1;
      bus.i_wb_rd    = rd;
      cyc(1);
      bus.i_wb_valid = 1'b0;
   endtask

   initial begin
      rstn = 1'b0;
      bus.i_dque_sch_ready = 0; bus.i_d0_valid = 0; bus.i_d1_valid = 0;
      bus.i_d0_funct = 0; bus.i_d0_rd = 0; bus.i_d0_rs1 = 0; bus.i_d0_rs2 = 0; bus.i_d0_rd_wr = 0;
      bus.i_d1_funct = 0; bus.i_d1_rd = 0; bus.i_d1_rs1 = 0; bus.i_d1_rs2 = 0; bus.i_d1_rd_wr = 0;
      bus.i_iss0_ready = 1; bus.i_iss1_ready = 1;
      bus.i_wb_valid = 0; bus.i_wb_rd = 0; bus.i_flush = 0;
      cyc(2);
      chk("reset_request", bus.o_sch_dque_request, 1);
      chk("reset_valids", {bus.o_iss0_valid, bus.o_iss1_valid}, 0);
      chk("reset_payload", {bus.o_iss0_funct, bus.o_iss0_rd, bus.o_iss1_rd}, 0);
      rstn = 1'b1;

      // independent ALU + MUL pair dual-issues
      send(mk(0, 1, 2, 3, 1), 1, mk(3, 4, 5, 6, 1), 1);
      #1;
      chk("dual_p0", {bus.o_iss0_valid, bus.o_iss0_funct, bus.o_iss0_rd}, {1'b1, 3'd0, 5'd1});
      chk("dual_p1", {bus.o_iss1_valid, bus.o_iss1_funct, bus.o_iss1_rd}, {1'b1, 3'd3, 5'd4});
      chk("dual_request", bus.o_sch_dque_request, 1);
      cyc(1); wb(1); wb(4);

      // DIV + ALU: exclusive slot0 goes to port1, ALU takes port0
      send(mk(4, 27, 0, 0, 1), 1, mk(0, 28, 0, 0, 1), 1);
      #1;
      chk("route_p1_div", {bus.o_iss1_valid, bus.o_iss1_funct, bus.o_iss1_rd}, {1'b1, 3'd4, 5'd27});
      chk("route_p0_alu", {bus.o_iss0_valid, bus.o_iss0_rd}, {1'b1, 5'd28});
      cyc(1); wb(27); wb(28);

      // RAW: slot1 waits for writeback of r5
      send(mk(0, 5, 10, 11, 1), 1, mk(0, 12, 5, 0, 1), 1);
      #1;
      chk("raw_slot0", {bus.o_iss0_valid, bus.o_iss0_rd, bus.o_iss1_valid}, {1'b1, 5'd5, 1'b0});
      chk("raw_request", bus.o_sch_dque_request, 0);
      cyc(1); #1;
      chk("raw_stall", {bus.o_iss0_valid, bus.o_iss1_valid}, 0);
      cyc(1); wb(5); #1;
      chk("raw_after_wb", {bus.o_iss0_valid, bus.o_iss0_rd}, {1'b1, 5'd12});
      cyc(1); wb(12);

      // LSU + BRC share port0: serialized
      send(mk(2, 13, 0, 0, 1), 1, mk(1, 0, 0, 0, 0), 1);
      #1;
      chk("lsu_first", {bus.o_iss0_valid, bus.o_iss0_funct, bus.o_iss1_valid}, {1'b1, 3'd2, 1'b0});
      cyc(1); #1;
      chk("brc_second", {bus.o_iss0_valid, bus.o_iss0_funct}, {1'b1, 3'd1});
      cyc(1); wb(13);

      // single ALU falls back to port1, then both ports blocked
      bus.i_iss0_ready = 0;
      send(mk(0, 14, 0, 0, 1), 1, '0, 0);
      #1;
      chk("alu_fallback", {bus.o_iss0_valid, bus.o_iss1_valid, bus.o_iss1_rd}, {1'b0, 1'b1, 5'd14});
      cyc(1);
      bus.i_iss1_ready = 0;
      send(mk(0, 15, 0, 0, 1), 1, '0, 0);
      cyc(2); #1;
      chk("no_ready_hold", {bus.o_iss0_valid, bus.o_iss1_valid, bus.o_sch_dque_request}, 0);
      bus.i_iss0_ready = 1; bus.i_iss1_ready = 1; #1;
      chk("ready_release", {bus.o_iss0_valid, bus.o_iss0_rd}, {1'b1, 5'd15});
      cyc(1); wb(14); wb(15);

      // WAW on r7
      send(mk(0, 7, 0, 0, 1), 1, mk(0, 7, 0, 0, 1), 1);
      #1;
      chk("waw_first", {bus.o_iss0_valid, bus.o_iss0_rd, bus.o_iss1_valid}, {1'b1, 5'd7, 1'b0});
      cyc(1); wb(7); #1;
      chk("waw_second", {bus.o_iss0_valid, bus.o_iss0_rd}, {1'b1, 5'd7});
      cyc(1); wb(7);

      // issue-set and writeback of r9 in the same cycle: set wins
      send(mk(0, 9, 0, 0, 1), 1, '0, 0);
      bus.i_wb_valid = 1; bus.i_wb_rd = 9; #1;
      chk("setwin_issue", {bus.o_iss0_valid, bus.o_iss0_rd}, {1'b1, 5'd9});
      cyc(1); bus.i_wb_valid = 0;
      send(mk(0, 20, 9, 0, 1), 1, '0, 0);
      #1;
      chk("setwin_stall", bus.o_iss0_valid, 0);
      wb(9); #1;
      chk("setwin_release", {bus.o_iss0_valid, bus.o_iss0_rd}, {1'b1, 5'd20});
      cyc(1); wb(20);

      // flush in HALF keeps the scoreboard
      send(mk(0, 21, 0, 0, 1), 1, mk(0, 22, 21, 0, 1), 1);
      cyc(1);
      bus.i_flush = 1; #1;
      chk("flush_outputs", {bus.o_iss0_valid, bus.o_iss1_valid, bus.o_sch_dque_request}, 3'b001);
      cyc(1); bus.i_flush = 0;
      send(mk(0, 23, 21, 0, 1), 1, '0, 0);
      #1;
      chk("flush_sb_kept", bus.o_iss0_valid, 0);
      wb(21); #1;
      chk("flush_release", {bus.o_iss0_valid, bus.o_iss0_rd}, {1'b1, 5'd23});
      cyc(1); wb(23);

      // empty pair
      send('0, 0, '0, 0);
      #1;
      chk("empty_pair", {bus.o_iss0_valid, bus.o_iss1_valid, bus.o_sch_dque_request}, 3'b001);
      cyc(1);

      // async reset mid-issue drops valids and clears the scoreboard
      send(mk(0, 30, 0, 0, 1), 1, '0, 0);
      cyc(1);
      send(mk(0, 24, 0, 0, 1), 1, mk(3, 25, 0, 0, 1), 1);
      #1;
      chk("pre_reset_dual", {bus.o_iss0_valid, bus.o_iss1_valid}, 2'b11);
      #1; rstn = 0; #1;
      chk("async_reset", {bus.o_iss0_valid, bus.o_iss1_valid, bus.o_sch_dque_request}, 3'b001);
      cyc(1); rstn = 1;
      send(mk(0, 26, 30, 0, 1), 1, '0, 0);
      #1;
      chk("reset_sb_clear", {bus.o_iss0_valid, bus.o_iss0_rd}, {1'b1, 5'd26});
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
`default_nettype wire
